mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory port between the fetch stage (IF) and the load/store stage (MEM).
- Serialises accesses with a 3-state FSM and drives stall signals back to the pipeline.
- The MEM requests come from the decoder's mem_read/mem_write controls.
- A watchdog counter flags a memory that never responds.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 62 ++++++
 rtl/arb_watchdog.sv | 33 +++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the unified memory port arbiter.
//   arb_state_t : arbiter FSM state (IDLE, REQ, WAIT)
//   owner_t     : which requester currently owns the memory port
//   DEFAULT_TIMEOUT_CYC : default watchdog budget in cycles (REQ + WAIT)
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DATA
    } owner_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYC = 255;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal around the memory port arbiter: the fetch request
// channel, the load/store request channel, the memory port itself and the
// pipeline stall / error outputs.
//   slave  : the arbiter's view (takes requests, drives memory and stalls)
//   master : the surrounding pipeline + memory model's view
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);

    // Fetch channel
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_kill;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_done;

    // Load/store channel
    logic                  d_read;
    logic                  d_write;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic [DATA_W-1:0]     d_rdata;
    logic                  d_done;

    // Memory port
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    // Pipeline control
    logic                  if_stall;
    logic                  d_stall;
    logic                  bus_err;

    modport slave (
        input  if_req, if_addr, if_kill,
        output if_rdata, if_done,
        input  d_read, d_write, d_addr, d_wdata, d_wstrb,
        output d_rdata, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_stall, d_stall, bus_err
    );

    modport master (
        output if_req, if_addr, if_kill,
        input  if_rdata, if_done,
        output d_read, d_write, d_addr, d_wdata, d_wstrb,
        input  d_rdata, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_stall, d_stall, bus_err
    );

endinterface

// File: rtl/arb_watchdog.sv
// Transaction watchdog for the memory port arbiter.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : restart the count (a new transaction is being issued)
//   en       : a transaction is outstanding (REQ or WAIT)
//   expire   : the outstanding transaction has used its last allowed cycle
module arb_watchdog import cpu_pkg::*; #(
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire = en && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified instruction/data memory port between the fetch
// stage and the load/store stage. Data requests have fixed priority; one
// transaction is outstanding at a time (IDLE -> REQ -> WAIT -> IDLE).
//   clk, rst : clock and asynchronous active-high reset
//   bus      : fetch channel, load/store channel, memory port, stalls and
//              the sticky bus_err timeout flag (see mem_port_arbiter_if)
module mem_port_arbiter import cpu_pkg::*; #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_t            state_q;
    owner_t                owner_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_W-1:0]     mem_addr_q;
    logic [DATA_W-1:0]     mem_wdata_q;
    logic [DATA_W/8-1:0]   mem_wstrb_q;
    logic [DATA_W-1:0]     if_rdata_q;
    logic [DATA_W-1:0]     d_rdata_q;
    logic                  if_done_q;
    logic                  d_done_q;
    logic                  bus_err_q;
    logic                  killed_q;

    logic d_pend;
    logic if_pend;
    logic if_killed;
    logic wd_clr;
    logic wd_en;
    logic wd_expire;
    logic resp_exit;
    logic timeout;

    // A request is still pending until its done pulse; in the done cycle the
    // requester still shows the old request, so it must not be re-issued.
    assign d_pend    = (bus.d_read | bus.d_write) & ~d_done_q;
    assign if_pend   = bus.if_req & ~if_done_q & ~bus.if_kill;
    assign if_killed = killed_q | bus.if_kill;

    assign wd_clr    = (state_q == IDLE) && (d_pend || if_pend);
    assign wd_en     = (state_q != IDLE);
    assign resp_exit = (state_q == WAIT) && bus.mem_rvalid;
    assign timeout   = wd_expire && !resp_exit;

    arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            killed_q    <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;

            // A flush during an in-flight fetch is remembered so the late
            // response is swallowed even after if_kill has dropped.
            if (state_q != IDLE && owner_q == OWN_IF && bus.if_kill) begin
                killed_q <= 1'b1;
            end

            if (timeout) begin
                bus_err_q <= 1'b1;
                mem_req_q <= 1'b0;
                state_q   <= IDLE;
                owner_q   <= OWN_NONE;
                if (owner_q == OWN_DATA) begin
                    d_done_q  <= 1'b1;
                    d_rdata_q <= '0;
                end else if (owner_q == OWN_IF && !if_killed) begin
                    if_done_q  <= 1'b1;
                    if_rdata_q <= '0;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (d_pend) begin
                            mem_addr_q  <= bus.d_addr;
                            mem_wdata_q <= bus.d_wdata;
                            mem_wstrb_q <= bus.d_wstrb;
                            mem_we_q    <= bus.d_write;
                            mem_req_q   <= 1'b1;
                            owner_q     <= OWN_DATA;
                            killed_q    <= 1'b0;
                            state_q     <= REQ;
                        end else if (if_pend) begin
                            mem_addr_q  <= bus.if_addr;
                            mem_wstrb_q <= '0;
                            mem_we_q    <= 1'b0;
                            mem_req_q   <= 1'b1;
                            owner_q     <= OWN_IF;
                            killed_q    <= 1'b0;
                            state_q     <= REQ;
                        end
                    end
                    REQ: begin
                        // mem_req is held even across a flush: the handshake
                        // cannot be withdrawn once offered.
                        if (bus.mem_gnt) begin
                            mem_req_q <= 1'b0;
                            state_q   <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (bus.mem_rvalid) begin
                            state_q <= IDLE;
                            owner_q <= OWN_NONE;
                            if (owner_q == OWN_DATA) begin
                                d_done_q <= 1'b1;
                                if (!mem_we_q) begin
                                    d_rdata_q <= bus.mem_rdata;
                                end
                            end else if (owner_q == OWN_IF && !if_killed) begin
                                if_done_q  <= 1'b1;
                                if_rdata_q <= bus.mem_rdata;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.bus_err   = bus_err_q;

    assign bus.if_stall  = bus.if_req & ~if_done_q;
    assign bus.d_stall   = (bus.d_read | bus.d_write) & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (watchdog budget 8).
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.if_kill    = 1'b0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_wstrb    = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.if_done, bus.d_done, bus.bus_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {bus.mem_req, bus.mem_we, bus.if_done, bus.d_done, bus.bus_err});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.if_rdata, bus.d_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h wstrb %h if_rdata %h d_rdata %h required 0",
                     bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.if_rdata, bus.d_rdata);
        end
        checks++;
        if ({bus.if_stall, bus.d_stall} !== 2'b00) begin
            errors++;
            $display("FAIL reset_stall: got %b required 00", {bus.if_stall, bus.d_stall});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_fetch();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        #1;
        checks++;
        if ({bus.if_stall, bus.mem_req} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_c0: stall,req got %b required 10", {bus.if_stall, bus.mem_req});
        end
        step();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.if_stall} !== 3'b101 || bus.mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL fetch_c1: req,we,stall %b addr %h required 101 00000100",
                     {bus.mem_req, bus.mem_we, bus.if_stall}, bus.mem_addr);
        end
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0050_0093;
        checks++;
        if ({bus.mem_req, bus.if_stall, bus.if_done} !== 3'b010) begin
            errors++;
            $display("FAIL fetch_c2: req,stall,done got %b required 010",
                     {bus.mem_req, bus.if_stall, bus.if_done});
        end
        step();
        bus.mem_rvalid = 1'b0;
        checks++;
        if ({bus.if_done, bus.d_done, bus.if_stall} !== 3'b100 || bus.if_rdata !== 32'h0050_0093) begin
            errors++;
            $display("FAIL fetch_c3: done,d_done,stall %b rdata %h required 100 00500093",
                     {bus.if_done, bus.d_done, bus.if_stall}, bus.if_rdata);
        end
        bus.if_req = 1'b0;
        step();
        checks++;
        if ({bus.if_done, bus.mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_c4: done,req got %b required 00", {bus.if_done, bus.mem_req});
        end
    endtask

    task automatic test_simultaneous();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        bus.d_read  = 1'b1;
        bus.d_addr  = 32'h2000;
        step();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h2000) begin
            errors++;
            $display("FAIL sim_data_first: req %b we %b addr %h required 1 0 00002000",
                     bus.mem_req, bus.mem_we, bus.mem_addr);
        end
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1111_2222;
        step();
        bus.mem_rvalid = 1'b0;
        checks++;
        if ({bus.d_done, bus.if_done, bus.if_stall} !== 3'b101 || bus.d_rdata !== 32'h1111_2222) begin
            errors++;
            $display("FAIL sim_d_done: d_done,if_done,if_stall %b d_rdata %h required 101 11112222",
                     {bus.d_done, bus.if_done, bus.if_stall}, bus.d_rdata);
        end
        bus.d_read = 1'b0;
        step();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h300) begin
            errors++;
            $display("FAIL sim_fetch_issue: req %b addr %h required 1 00000300",
                     bus.mem_req, bus.mem_addr);
        end
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h3333_4444;
        step();
        bus.mem_rvalid = 1'b0;
        checks++;
        if ({bus.if_done, bus.d_done} !== 2'b10 || bus.if_rdata !== 32'h3333_4444) begin
            errors++;
            $display("FAIL sim_if_done: if_done,d_done %b if_rdata %h required 10 33334444",
                     {bus.if_done, bus.d_done}, bus.if_rdata);
        end
        bus.if_req = 1'b0;
        step();
    endtask

    task automatic test_store();
        bus.d_write = 1'b1;
        bus.d_addr  = 32'h40;
        bus.d_wdata = 32'hDEAD_BEEF;
        bus.d_wstrb = 4'b0011;
        step();
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.d_stall} !== 3'b111 || bus.mem_addr !== 32'h40 ||
            bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_wstrb !== 4'b0011) begin
            errors++;
            $display("FAIL store_bus: req,we,stall %b addr %h wdata %h wstrb %b required 111 40 deadbeef 0011",
                     {bus.mem_req, bus.mem_we, bus.d_stall}, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
        end
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        step();
        bus.mem_rvalid = 1'b0;
        checks++;
        if ({bus.d_done, bus.d_stall} !== 2'b10 || bus.d_rdata !== 32'h1111_2222) begin
            errors++;
            $display("FAIL store_done: d_done,d_stall %b d_rdata %h required 10 11112222",
                     {bus.d_done, bus.d_stall}, bus.d_rdata);
        end
        bus.d_write = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h500;
        step();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h500) begin
                errors++;
                $display("FAIL bp_hold[%0d]: req %b addr %h required 1 00000500",
                         i, bus.mem_req, bus.mem_addr);
            end
            step();
        end
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0BAD_CAFE;
        checks++;
        if ({bus.mem_req, bus.if_done} !== 2'b00) begin
            errors++;
            $display("FAIL bp_after_gnt: req,done got %b required 00", {bus.mem_req, bus.if_done});
        end
        step();
        bus.mem_rvalid = 1'b0;
        checks++;
        if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h0BAD_CAFE) begin
            errors++;
            $display("FAIL bp_done: done %b rdata %h required 1 0badcafe", bus.if_done, bus.if_rdata);
        end
        bus.if_req = 1'b0;
        step();
    endtask

    task automatic test_kill();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h600;
        step();
        bus.mem_gnt = 1'b1;
        step();
        // Flush while the fetch waits for its response; requester drops too.
        bus.mem_gnt = 1'b0;
        bus.if_kill = 1'b1;
        bus.if_req  = 1'b0;
        step();
        bus.if_kill    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h9999_9999;
        step();
        bus.mem_rvalid = 1'b0;
        checks++;
        if ({bus.if_done, bus.mem_req} !== 2'b00 || bus.if_rdata !== 32'h0BAD_CAFE) begin
            errors++;
            $display("FAIL kill_suppress: done,req %b rdata %h required 00 0badcafe",
                     {bus.if_done, bus.mem_req}, bus.if_rdata);
        end
        // Kill in IDLE blocks arbitration for that cycle.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h700;
        bus.if_kill = 1'b1;
        step();
        checks++;
        if (bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle_block: req got %b required 0", bus.mem_req);
        end
        bus.if_kill = 1'b0;
        step();
        checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h700) begin
            errors++;
            $display("FAIL kill_next_issue: req %b addr %h required 1 00000700",
                     bus.mem_req, bus.mem_addr);
        end
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h7777_7777;
        step();
        bus.mem_rvalid = 1'b0;
        checks++;
        if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h7777_7777) begin
            errors++;
            $display("FAIL kill_next_done: done %b rdata %h required 1 77777777",
                     bus.if_done, bus.if_rdata);
        end
        bus.if_req = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        bus.d_read = 1'b1;
        bus.d_addr = 32'h80;
        step();
        // Seven more REQ cycles; the eighth REQ cycle is the last allowed one.
        for (int i = 0; i < 7; i++) step();
        checks++;
        if ({bus.mem_req, bus.bus_err, bus.d_done} !== 3'b100) begin
            errors++;
            $display("FAIL to_last_req: req,err,done got %b required 100",
                     {bus.mem_req, bus.bus_err, bus.d_done});
        end
        step();
        checks++;
        if ({bus.mem_req, bus.bus_err, bus.d_done} !== 3'b011 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL to_abort: req,err,done %b d_rdata %h required 011 00000000",
                     {bus.mem_req, bus.bus_err, bus.d_done}, bus.d_rdata);
        end
        bus.d_read = 1'b0;
        step();
        // Late response in IDLE must be ignored.
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h5555_AAAA;
        step();
        bus.mem_rvalid = 1'b0;
        step();
        checks++;
        if ({bus.d_done, bus.if_done, bus.mem_req, bus.bus_err} !== 4'b0001 ||
            bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL to_late_rvalid: d_done,if_done,req,err %b d_rdata %h required 0001 00000000",
                     {bus.d_done, bus.if_done, bus.mem_req, bus.bus_err}, bus.d_rdata);
        end
        // Reset in the middle of a fetch clears everything at once.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h900;
        step();
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: req got %b required 1", bus.mem_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.mem_req, bus.bus_err} !== 2'b00 || bus.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_async: req,err %b addr %h required 00 00000000",
                     {bus.mem_req, bus.bus_err}, bus.mem_addr);
        end
        bus.if_req = 1'b0;
        step();
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        step();
        bus.mem_rvalid = 1'b0;
        step();
        checks++;
        if ({bus.if_done, bus.d_done, bus.bus_err} !== 3'b000) begin
            errors++;
            $display("FAIL rst_no_done: if_done,d_done,err got %b required 000",
                     {bus.if_done, bus.d_done, bus.bus_err});
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_store();
        test_backpressure();
        test_kill();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
